// File: rtl/int_pkg.sv
// Shared sizing constants, FSM encoding and the nesting-threshold helper
// for the interrupt priority controller.
package int_pkg;
  localparam int N_SRC  = 8;
  localparam int TYPE_W = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  // Sources strictly above the highest active handler may preempt; with no
  // active handler every source qualifies.
  function automatic logic [N_SRC-1:0] above_mask(input logic [TYPE_W-1:0] idx,
                                                  input logic              valid);
    above_mask = '1;
    if (valid) begin
      for (int i = 0; i < N_SRC; i++) begin
        above_mask[i] = (TYPE_W'(i) > idx);
      end
    end
  endfunction
endpackage

// File: rtl/prio_enc8.sv
// 8-input priority encoder: reports the highest set bit index and whether
// any bit is set.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_priority_ctrl.sv
// Nested, fixed-priority interrupt controller: synchronises level lines,
// latches rising edges and raises one stable request at a time to the CPU.
module int_priority_ctrl #(
  parameter int N_SRC  = 8,
  parameter int TYPE_W = 3
) (
  input  logic              clk_10hz,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic              int_ack,
  input  logic              int_ret,
  output logic              Interrupt,
  output logic [TYPE_W-1:0] Int_type,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  in_service,
  output logic [N_SRC-1:0]  mask
);
  import int_pkg::*;

  logic [N_SRC-1:0]  sync1, sync2, hist;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  pending_nxt, in_service_nxt;
  logic [TYPE_W-1:0] elig_idx, svc_idx;
  logic              elig_valid, svc_valid;
  logic [0:0]        state;
  logic              ack_fire;

  assign rise      = sync2 & ~hist;
  assign ack_fire  = int_ack && (state == REQ);
  assign Interrupt = (state == REQ);
  assign eligible  = pending & ~mask & above_mask(svc_idx, svc_valid);

  prio_enc8 u_elig_enc (
    .req   (eligible),
    .idx   (elig_idx),
    .valid (elig_valid)
  );

  prio_enc8 u_svc_enc (
    .req   (in_service),
    .idx   (svc_idx),
    .valid (svc_valid)
  );

  // Ack clears before new edges are merged so a coincident edge survives;
  // ret retires the innermost handler before ack records the new one.
  always_comb begin
    pending_nxt    = pending;
    in_service_nxt = in_service;
    if (ack_fire) begin
      pending_nxt[Int_type] = 1'b0;
    end
    pending_nxt = pending_nxt | rise;
    if (int_ret && svc_valid) begin
      in_service_nxt[svc_idx] = 1'b0;
    end
    if (ack_fire) begin
      in_service_nxt[Int_type] = 1'b1;
    end
  end

  always_ff @(posedge clk_10hz or negedge rst) begin
    if (!rst) begin
      sync1      <= '0;
      sync2      <= '0;
      hist       <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
      state      <= IDLE;
      Int_type   <= '0;
    end else begin
      sync1      <= irq_in;
      sync2      <= sync1;
      hist       <= sync2;
      pending    <= pending_nxt;
      in_service <= in_service_nxt;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      // Int_type only moves when leaving IDLE, so a live request never retargets.
      case (state)
        IDLE: begin
          if (elig_valid) begin
            Int_type <= elig_idx;
            state    <= REQ;
          end
        end
        default: begin
          if (int_ack) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed bench for int_priority_ctrl: a per-cycle vector table followed by
// hand-written nesting, coincident-event and asynchronous-reset sequences.
module tb_int_priority_ctrl;

  logic       clk_10hz;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       int_ack;
  logic       int_ret;
  logic       Interrupt;
  logic [2:0] Int_type;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] mask;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       ret;
    logic       intr;
    logic [2:0] typ;
    logic [7:0] pend;
    logic [7:0] insv;
    logic [7:0] msk;
  } vec_t;

  vec_t vecs[$];

  int_priority_ctrl #(.N_SRC(8), .TYPE_W(3)) dut (
    .clk_10hz   (clk_10hz),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .Interrupt  (Interrupt),
    .Int_type   (Int_type),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask)
  );

  initial begin
    clk_10hz = 1'b0;
    forever #5 clk_10hz = ~clk_10hz;
  end

  function automatic vec_t mk(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                              input logic ack, input logic ret, input logic intr,
                              input logic [2:0] typ, input logic [7:0] pend,
                              input logic [7:0] insv, input logic [7:0] msk);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.ret = ret;
    v.intr = intr; v.typ = typ; v.pend = pend; v.insv = insv; v.msk = msk;
    return v;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic intr, input logic [2:0] typ,
                              input logic [7:0] pend, input logic [7:0] insv,
                              input logic [7:0] msk);
    check8({name, "_intr"}, {7'b0, Interrupt}, {7'b0, intr});
    check8({name, "_type"}, {5'b0, Int_type}, {5'b0, typ});
    check8({name, "_pend"}, pending, pend);
    check8({name, "_insv"}, in_service, insv);
    check8({name, "_mask"}, mask, msk);
  endtask

  // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
  task automatic apply_stimulus(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                                input logic ack, input logic ret);
    @(negedge clk_10hz);
    irq_in     = irq;
    mask_we    = mwe;
    mask_wdata = mwd;
    int_ack    = ack;
    int_ret    = ret;
    @(posedge clk_10hz);
    #1;
  endtask

  task automatic idle_steps(input logic [7:0] irq, input int n);
    for (int k = 0; k < n; k++) apply_stimulus(irq, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    irq_in     = 8'h00;
    mask_we    = 1'b0;
    mask_wdata = 8'h00;
    int_ack    = 1'b0;
    int_ret    = 1'b0;

    // Columns: irq, mwe, mwd, ack, ret | Interrupt, Int_type, pending, in_service, mask
    vecs.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 3'd0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 3'd0, 8'h04, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 0, 8'h00, 0, 0,  1, 3'd2, 8'h04, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 0, 8'h00, 1, 0,  0, 3'd2, 8'h00, 8'h04, 8'h00));
    vecs.push_back(mk(8'h04, 0, 8'h00, 0, 1,  0, 3'd2, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h04, 1, 8'h10, 0, 0,  0, 3'd2, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0,  0, 3'd2, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0,  0, 3'd2, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0,  0, 3'd2, 8'h10, 8'h00, 8'h10));
    vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0,  0, 3'd2, 8'h10, 8'h00, 8'h10));
    vecs.push_back(mk(8'h14, 1, 8'h00, 0, 0,  0, 3'd2, 8'h10, 8'h00, 8'h00));
    vecs.push_back(mk(8'h14, 0, 8'h00, 0, 0,  1, 3'd4, 8'h10, 8'h00, 8'h00));
    vecs.push_back(mk(8'h14, 1, 8'h10, 0, 0,  1, 3'd4, 8'h10, 8'h00, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 0, 0,  1, 3'd4, 8'h10, 8'h00, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 0, 0,  1, 3'd4, 8'h10, 8'h00, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 0, 0,  1, 3'd4, 8'h90, 8'h00, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 1, 0,  0, 3'd4, 8'h80, 8'h10, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 0, 0,  1, 3'd7, 8'h80, 8'h10, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 1, 0,  0, 3'd7, 8'h00, 8'h90, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 0, 1,  0, 3'd7, 8'h00, 8'h10, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 0, 1,  0, 3'd7, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(8'h94, 0, 8'h00, 1, 1,  0, 3'd7, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(8'h00, 1, 8'h00, 0, 0,  0, 3'd7, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd7, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h00, 0, 8'h00, 0, 0,  0, 3'd7, 8'h00, 8'h00, 8'h00));

    #12;
    check_output("in_reset", 0, 3'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk_10hz);
    rst = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].irq, vecs[i].mwe, vecs[i].mwd, vecs[i].ack, vecs[i].ret);
      check_output($sformatf("vec%0d", i), vecs[i].intr, vecs[i].typ, vecs[i].pend,
                   vecs[i].insv, vecs[i].msk);
    end

    // Simultaneous edges on 0 and 7; 0 must wait until 7's handler returns.
    idle_steps(8'h81, 3);
    check_output("s1_pend", 0, 3'd7, 8'h81, 8'h00, 8'h00);
    idle_steps(8'h81, 1);
    check_output("s1_req7", 1, 3'd7, 8'h81, 8'h00, 8'h00);
    apply_stimulus(8'h81, 0, 8'h00, 1, 0);
    check_output("s1_ack7", 0, 3'd7, 8'h01, 8'h80, 8'h00);
    for (int k = 0; k < 3; k++) begin
      idle_steps(8'h81, 1);
      check_output($sformatf("s1_hold%0d", k), 0, 3'd7, 8'h01, 8'h80, 8'h00);
    end
    apply_stimulus(8'h81, 0, 8'h00, 0, 1);
    check_output("s1_ret7", 0, 3'd7, 8'h01, 8'h00, 8'h00);
    idle_steps(8'h81, 1);
    check_output("s1_req0", 1, 3'd0, 8'h01, 8'h00, 8'h00);
    apply_stimulus(8'h81, 0, 8'h00, 1, 0);
    check_output("s1_ack0", 0, 3'd0, 8'h00, 8'h01, 8'h00);
    apply_stimulus(8'h81, 0, 8'h00, 0, 1);
    idle_steps(8'h00, 3);
    check_output("s1_done", 0, 3'd0, 8'h00, 8'h00, 8'h00);

    // Nesting: source 5 preempts active handler 3.
    idle_steps(8'h08, 4);
    check_output("s2_req3", 1, 3'd3, 8'h08, 8'h00, 8'h00);
    apply_stimulus(8'h08, 0, 8'h00, 1, 0);
    check_output("s2_ack3", 0, 3'd3, 8'h00, 8'h08, 8'h00);
    idle_steps(8'h28, 3);
    check_output("s2_pend5", 0, 3'd3, 8'h20, 8'h08, 8'h00);
    idle_steps(8'h28, 1);
    check_output("s2_req5", 1, 3'd5, 8'h20, 8'h08, 8'h00);
    apply_stimulus(8'h28, 0, 8'h00, 1, 0);
    check_output("s2_ack5", 0, 3'd5, 8'h00, 8'h28, 8'h00);
    apply_stimulus(8'h28, 0, 8'h00, 0, 1);
    check_output("s2_ret5", 0, 3'd5, 8'h00, 8'h08, 8'h00);
    apply_stimulus(8'h28, 0, 8'h00, 0, 1);
    check_output("s2_ret3", 0, 3'd5, 8'h00, 8'h00, 8'h00);
    idle_steps(8'h00, 3);

    // Edge on the ack cycle re-pends; ret+ack together retire before recording.
    idle_steps(8'h02, 4);
    check_output("s3_req1", 1, 3'd1, 8'h02, 8'h00, 8'h00);
    apply_stimulus(8'h02, 0, 8'h00, 1, 0);
    check_output("s3_ack1", 0, 3'd1, 8'h00, 8'h02, 8'h00);
    idle_steps(8'h0A, 4);
    check_output("s3_req3", 1, 3'd3, 8'h08, 8'h02, 8'h00);
    idle_steps(8'h02, 3);
    check_output("s3_held", 1, 3'd3, 8'h08, 8'h02, 8'h00);
    idle_steps(8'h0A, 2);
    apply_stimulus(8'h0A, 0, 8'h00, 1, 0);
    check_output("s3_ack_edge", 0, 3'd3, 8'h08, 8'h0A, 8'h00);
    idle_steps(8'h0A, 1);
    check_output("s3_blocked", 0, 3'd3, 8'h08, 8'h0A, 8'h00);
    apply_stimulus(8'h0A, 0, 8'h00, 0, 1);
    check_output("s3_ret3", 0, 3'd3, 8'h08, 8'h02, 8'h00);
    idle_steps(8'h0A, 1);
    check_output("s3_req3b", 1, 3'd3, 8'h08, 8'h02, 8'h00);
    apply_stimulus(8'h0A, 0, 8'h00, 1, 1);
    check_output("s3_ack_ret", 0, 3'd3, 8'h00, 8'h08, 8'h00);
    apply_stimulus(8'h0A, 0, 8'h00, 0, 1);
    idle_steps(8'h00, 3);
    check_output("s3_done", 0, 3'd3, 8'h00, 8'h00, 8'h00);

    // Reset asserted mid-request drops everything without a clock edge.
    apply_stimulus(8'h40, 1, 8'h01, 0, 0);
    idle_steps(8'h40, 3);
    check_output("s4_req6", 1, 3'd6, 8'h40, 8'h00, 8'h01);
    @(negedge clk_10hz);
    #2;
    rst = 1'b0;
    #1;
    check_output("s4_async_rst", 0, 3'd0, 8'h00, 8'h00, 8'h00);
    irq_in = 8'h00;
    @(negedge clk_10hz);
    @(negedge clk_10hz);
    rst = 1'b1;
    idle_steps(8'h00, 1);
    check_output("s4_after_rst", 0, 3'd0, 8'h00, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
